// File: rtl/ultrasonido_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ultrasonido_pkg
// Shared definitions for the ultrasonic range-finder measurement sequencer:
// the sequencer state enumeration, default timing constants for a 50 MHz
// clock, the distance width and saturation value, and a helper that sizes
// the shared cycle counters from the timing parameters.
// ----------------------------------------------------------------------------
package ultrasonido_pkg;

    // Sequencer states, in the order a normal measurement walks through them
    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        DONE,
        HOLDOFF
    } state_e;

    // Default timing at 50 MHz
    localparam int TRIG_CYCLES_DEF    = 500;        // 10 us trigger pulse
    localparam int CYCLES_PER_CM_DEF  = 2900;       // 58 us of echo per cm
    localparam int WAIT_CYCLES_DEF    = 1_500_000;  // 30 ms to see an echo
    localparam int HOLDOFF_CYCLES_DEF = 3_000_000;  // 60 ms between shots

    // Distance result width and the value reported for no-echo/over-range
    localparam int         DIST_W   = 8;
    localparam logic [7:0] DIST_MAX = 8'd255;

    // Bits needed by a counter that runs 0..max(a,b,c)-1
    function automatic int cntWidth(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/ultrasonido_ctrl_if.sv
// ----------------------------------------------------------------------------
// ultrasonido_ctrl_if
// Groups the sensor and result signals of the range-finder sequencer.
//   ENABLE    : level, high = run repeated measurements
//   ECHO      : raw sensor echo, asynchronous to clk
//   TRIGGER   : registered sensor trigger pulse
//   distance  : last result in cm (saturating at 255)
//   valid     : one-cycle strobe when distance/error/overrange update
//   error     : last measurement saw no echo
//   overrange : last measurement saturated at 255 cm
//   busy      : sequencer not idle
// master = the side driving ENABLE/ECHO (system/sensor, testbench);
// slave  = the sequencer itself.
// ----------------------------------------------------------------------------
interface ultrasonido_ctrl_if;
    import ultrasonido_pkg::*;

    logic              ENABLE;
    logic              ECHO;
    logic              TRIGGER;
    logic [DIST_W-1:0] distance;
    logic              valid;
    logic              error;
    logic              overrange;
    logic              busy;

    modport master (
        output ENABLE, ECHO,
        input  TRIGGER, distance, valid, error, overrange, busy
    );

    modport slave (
        input  ENABLE, ECHO,
        output TRIGGER, distance, valid, error, overrange, busy
    );

endinterface

// File: rtl/ultrasonido_ctrl_echo_sync.sv
// ----------------------------------------------------------------------------
// echo_sync
// Brings the raw ECHO input into the clk domain through a two-flop
// synchroniser and produces registered single-cycle rise/fall pulses of the
// synchronised level.
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   echo_i : raw echo from the sensor
//   rise_o : one-cycle pulse after the synchronised echo goes 0 -> 1
//   fall_o : one-cycle pulse after the synchronised echo goes 1 -> 0
// ----------------------------------------------------------------------------
module echo_sync (
    input  logic clk,
    input  logic reset,
    input  logic echo_i,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic echoS_q;
    logic echoPrev_q;
    logic rise_q;
    logic fall_q;

    // Two metastability flops, then the previous synchronised level and the
    // registered edge pulses. Registering the pulses keeps the sequencer's
    // view of both edges delayed by the same amount.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b0;
            echoS_q    <= 1'b0;
            echoPrev_q <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            sync1_q    <= echo_i;
            echoS_q    <= sync1_q;
            echoPrev_q <= echoS_q;
            rise_q     <= echoS_q & ~echoPrev_q;
            fall_q     <= ~echoS_q & echoPrev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/ultrasonido_ctrl.sv
// ----------------------------------------------------------------------------
// ultrasonido_ctrl
// Measurement sequencer for the ultrasonic range finder. Fires a TRIGGER
// pulse, waits for the echo to rise, times the echo in centimetre units,
// reports the result with a one-cycle valid strobe and then stays quiet for
// a hold-off period before the next shot. No echo within the wait window
// reports distance 255 with error set; an echo longer than 255 cm ends the
// measurement early with distance 255 and overrange set.
//   clk   : system clock (50 MHz nominal)
//   reset : asynchronous, active-low reset
//   bus   : sensor/result signals (see ultrasonido_ctrl_if)
// ----------------------------------------------------------------------------
module ultrasonido_ctrl
    import ultrasonido_pkg::*;
#(
    parameter int TRIG_CYCLES    = TRIG_CYCLES_DEF,
    parameter int CYCLES_PER_CM  = CYCLES_PER_CM_DEF,
    parameter int WAIT_CYCLES    = WAIT_CYCLES_DEF,
    parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    ultrasonido_ctrl_if.slave bus
);

    localparam int CNT_W   = cntWidth(TRIG_CYCLES, WAIT_CYCLES, HOLDOFF_CYCLES);
    localparam int PRESC_W = cntWidth(CYCLES_PER_CM, 1, 1);

    localparam logic [CNT_W-1:0]   TRIG_LAST  = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0]   WAIT_LAST  = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CYCLES_PER_CM - 1);

    state_e              state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [PRESC_W-1:0]  presc_q,     presc_d;
    logic [DIST_W-1:0]   cm_q,        cm_d;
    logic                noEcho_q,    noEcho_d;
    logic                sat_q,       sat_d;
    logic                trigger_q,   trigger_d;
    logic                valid_q,     valid_d;
    logic [DIST_W-1:0]   distance_q,  distance_d;
    logic                error_q,     error_d;
    logic                overrange_q, overrange_d;

    logic echoRise;
    logic echoFall;

    echo_sync u_echo_sync (
        .clk    (clk),
        .reset  (reset),
        .echo_i (bus.ECHO),
        .rise_o (echoRise),
        .fall_o (echoFall)
    );

    // State, counters and registered outputs. Every output is a flop so the
    // sensor and the display chain never see combinational glitches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            presc_q     <= '0;
            cm_q        <= '0;
            noEcho_q    <= 1'b0;
            sat_q       <= 1'b0;
            trigger_q   <= 1'b0;
            valid_q     <= 1'b0;
            distance_q  <= '0;
            error_q     <= 1'b0;
            overrange_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            presc_q     <= presc_d;
            cm_q        <= cm_d;
            noEcho_q    <= noEcho_d;
            sat_q       <= sat_d;
            trigger_q   <= trigger_d;
            valid_q     <= valid_d;
            distance_q  <= distance_d;
            error_q     <= error_d;
            overrange_q <= overrange_d;
        end
    end

    // Next-state logic. One cycle counter is shared by TRIG, WAIT_ECHO and
    // HOLDOFF since only one of them runs at a time. TRIGGER is computed from
    // the next state so the registered pin is high exactly while in TRIG.
    // In MEASURE every cycle is counted: the rise and fall pulses pass through
    // the same pipeline, so the number of MEASURE cycles equals the number of
    // cycles ECHO was seen high.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        presc_d     = presc_q;
        cm_d        = cm_q;
        noEcho_d    = noEcho_q;
        sat_d       = sat_q;
        trigger_d   = 1'b0;
        valid_d     = 1'b0;
        distance_d  = distance_q;
        error_d     = error_q;
        overrange_d = overrange_q;

        unique case (state_q)
            IDLE: begin
                cnt_d    = '0;
                noEcho_d = 1'b0;
                sat_d    = 1'b0;
                if (bus.ENABLE) begin
                    state_d   = TRIG;
                    trigger_d = 1'b1;
                end
            end

            TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = WAIT_ECHO;
                    cnt_d   = '0;
                end else begin
                    trigger_d = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end

            // Only a fresh rise counts; an echo already high on entry never
            // produces one, so a stale echo is ignored until it cycles.
            WAIT_ECHO: begin
                if (echoRise) begin
                    state_d = MEASURE;
                    presc_d = '0;
                    cm_d    = '0;
                    cnt_d   = '0;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d  = DONE;
                    noEcho_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Partial final centimetre is dropped. Reaching 255 cm with the
            // echo still present ends the measurement without waiting for
            // the fall.
            MEASURE: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    cm_d    = cm_q + DIST_W'(1);
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
                if (echoFall) begin
                    state_d = DONE;
                end else if ((presc_q == PRESC_LAST) && (cm_q == DIST_MAX - DIST_W'(1))) begin
                    state_d = DONE;
                    sat_d   = 1'b1;
                end
            end

            DONE: begin
                valid_d     = 1'b1;
                distance_d  = noEcho_q ? DIST_MAX : cm_q;
                error_d     = noEcho_q;
                overrange_d = sat_q;
                state_d     = HOLDOFF;
                cnt_d       = '0;
            end

            HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.TRIGGER   = trigger_q;
    assign bus.valid     = valid_q;
    assign bus.distance  = distance_q;
    assign bus.error     = error_q;
    assign bus.overrange = overrange_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ultrasonido_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ultrasonido_ctrl
// Directed bench for the range-finder sequencer with shortened timing
// (TRIG 4, 10 cycles/cm, WAIT 100, HOLDOFF 20). Inputs change and outputs
// are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_ultrasonido_ctrl;
    import ultrasonido_pkg::*;

    localparam int TRIG_C = 4;
    localparam int CPC    = 10;
    localparam int WAIT_C = 100;
    localparam int HOLD_C = 20;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int checksRun    = 0;
    int checksPassed = 0;

    ultrasonido_ctrl_if bus();

    ultrasonido_ctrl #(
        .TRIG_CYCLES    (TRIG_C),
        .CYCLES_PER_CM  (CPC),
        .WAIT_CYCLES    (WAIT_C),
        .HOLDOFF_CYCLES (HOLD_C)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 100 MHz-style free-running clock; only cycle counts matter here
    always #5 clk = ~clk;

    // Hard stop in case something upstream hangs despite the bounded waits
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checksRun++;
        if (observed == expected) checksPassed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic en, input logic echo);
        bus.ENABLE = en;
        bus.ECHO   = echo;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Ticks until valid is seen; -1 if the budget runs out
    task automatic waitValid(input int budget, output int ticks);
        ticks = -1;
        for (int i = 1; i <= budget; i++) begin
            tick(1);
            if (bus.valid) begin
                ticks = i;
                break;
            end
        end
    endtask

    // Ticks until TRIGGER equals level; -1 if the budget runs out
    task automatic waitTrigger(input logic level, input int budget, output int ticks);
        ticks = -1;
        for (int i = 1; i <= budget; i++) begin
            tick(1);
            if (bus.TRIGGER == level) begin
                ticks = i;
                break;
            end
        end
    endtask

    initial begin
        int t;
        int highCnt;
        int validCnt;
        int firstAt;
        int satDist;
        int satErr;
        int satOvr;
        int trigCnt;

        // ---- 1: reset values, then the first trigger pulse ----
        applyStimulus(1'b0, 1'b0);
        reset = 1'b0;
        tick(3);
        checkOutput("rst_trigger",   bus.TRIGGER,   0);
        checkOutput("rst_distance",  bus.distance,  0);
        checkOutput("rst_valid",     bus.valid,     0);
        checkOutput("rst_error",     bus.error,     0);
        checkOutput("rst_overrange", bus.overrange, 0);
        checkOutput("rst_busy",      bus.busy,      0);

        applyStimulus(1'b1, 1'b0);
        reset = 1'b1;
        tick(1);
        checkOutput("t1_trig_first", bus.TRIGGER, 1);
        checkOutput("t1_busy",       bus.busy,    1);
        highCnt = 1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (bus.TRIGGER) highCnt++;
        end
        checkOutput("t1_trig_width", highCnt, TRIG_C);

        // ---- 2: 235-cycle echo -> 23 cm, valid 4 cycles after ECHO falls ----
        tick(20);
        applyStimulus(1'b1, 1'b1);
        tick(235);
        applyStimulus(1'b1, 1'b0);
        waitValid(20, t);
        // ECHO set low half a cycle before the sampling edge: 4 edges later
        // valid is high, observed on the fifth falling edge
        checkOutput("t2_latency",   t,             5);
        checkOutput("t2_distance",  bus.distance,  23);
        checkOutput("t2_error",     bus.error,     0);
        checkOutput("t2_overrange", bus.overrange, 0);
        tick(1);
        checkOutput("t2_valid_pulse", bus.valid,    0);
        checkOutput("t2_hold",        bus.distance, 23);
        // Next trigger 21 cycles after valid; one already spent above
        waitTrigger(1'b1, 40, t);
        checkOutput("t2_next_trig", t, 20);

        // ---- 3: no echo -> 255 cm with error ----
        waitTrigger(1'b0, 10, t);
        checkOutput("t3_trig_width", t, TRIG_C);
        waitValid(150, t);
        // 100 wait cycles plus the DONE cycle before the registered strobe
        checkOutput("t3_latency",   t,             WAIT_C + 1);
        checkOutput("t3_distance",  bus.distance,  255);
        checkOutput("t3_error",     bus.error,     1);
        checkOutput("t3_overrange", bus.overrange, 0);
        waitTrigger(1'b1, 40, t);
        checkOutput("t3_next_trig", t, HOLD_C + 1);

        // ---- 4: 3000-cycle echo saturates at 255 cm, single result ----
        waitTrigger(1'b0, 10, t);
        applyStimulus(1'b1, 1'b1);
        validCnt = 0;
        firstAt  = -1;
        satDist  = -1;
        satErr   = -1;
        satOvr   = -1;
        for (int i = 1; i <= 3000 + 60; i++) begin
            if (i == 50)   applyStimulus(1'b0, 1'b1);
            if (i == 3001) applyStimulus(1'b0, 1'b0);
            tick(1);
            if (bus.valid) begin
                validCnt++;
                if (firstAt < 0) begin
                    firstAt = i;
                    satDist = bus.distance;
                    satErr  = bus.error;
                    satOvr  = bus.overrange;
                end
            end
        end
        // 255 cm * 10 cycles of echo, plus 4 edges of pipeline and register
        checkOutput("t4_latency",   firstAt,  255 * CPC + 5);
        checkOutput("t4_distance",  satDist,  255);
        checkOutput("t4_overrange", satOvr,   1);
        checkOutput("t4_error",     satErr,   0);
        checkOutput("t4_one_result", validCnt, 1);
        checkOutput("t4_busy_idle", bus.busy, 0);

        // ---- 5: ENABLE dropped mid-measure, 57-cycle echo -> 5 cm ----
        applyStimulus(1'b1, 1'b0);
        waitTrigger(1'b1, 5, t);
        checkOutput("t5_trig_start", t, 1);
        waitTrigger(1'b0, 10, t);
        tick(5);
        applyStimulus(1'b1, 1'b1);
        tick(20);
        applyStimulus(1'b0, 1'b1);
        tick(37);
        applyStimulus(1'b0, 1'b0);
        waitValid(20, t);
        checkOutput("t5_latency",   t,             5);
        checkOutput("t5_distance",  bus.distance,  5);
        checkOutput("t5_error",     bus.error,     0);
        checkOutput("t5_overrange", bus.overrange, 0);
        tick(HOLD_C + 5);
        checkOutput("t5_busy_idle", bus.busy, 0);
        trigCnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (bus.TRIGGER) trigCnt++;
        end
        checkOutput("t5_no_trigger", trigCnt, 0);

        // ---- 6: stale echo ignored, then a real 100-cycle echo -> 10 cm ----
        applyStimulus(1'b0, 1'b1);
        tick(5);
        applyStimulus(1'b1, 1'b1);
        waitTrigger(1'b1, 5, t);
        waitTrigger(1'b0, 10, t);
        tick(10);
        checkOutput("t6_stale_busy",  bus.busy,  1);
        checkOutput("t6_stale_valid", bus.valid, 0);
        applyStimulus(1'b1, 1'b0);
        tick(30);
        applyStimulus(1'b1, 1'b1);
        tick(100);
        applyStimulus(1'b1, 1'b0);
        waitValid(20, t);
        checkOutput("t6_latency",  t,            5);
        checkOutput("t6_distance", bus.distance, 10);
        checkOutput("t6_error",    bus.error,    0);

        // Reset pulsed mid-trigger drops everything at once
        waitTrigger(1'b1, 40, t);
        tick(2);
        checkOutput("t6_trig_before_rst", bus.TRIGGER, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("t6_rst_trigger",  bus.TRIGGER,  0);
        checkOutput("t6_rst_busy",     bus.busy,     0);
        checkOutput("t6_rst_distance", bus.distance, 0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        reset = 1'b1;
        tick(3);
        checkOutput("t6_post_rst_trigger", bus.TRIGGER, 0);
        checkOutput("t6_post_rst_busy",    bus.busy,    0);

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule

// File: doc/ultrasonido_ctrl.md
Name: ultrasonido_ctrl

Overview:
Measurement sequencer for the ultrasonic range-finder datapath. It drives the sensor TRIGGER pulse, times the returning ECHO pulse in centimetre units, and detects no-echo and over-range conditions. It latches an 8-bit distance and re-arms after a hold-off period. Its distance and valid outputs feed the existing BCD conversion and display-multiplex chain in place of the free-running echo counter.

Parameters:
TRIG_CYCLES, 500, trigger high time in clk cycles (10 us at 50 MHz)
CYCLES_PER_CM, 2900, clk cycles per centimetre of range (58 us round trip)
WAIT_CYCLES, 1_500_000, maximum wait from trigger end to echo rise (30 ms)
HOLDOFF_CYCLES, 3_000_000, quiet time after each result before the next trigger (60 ms)

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
ENABLE  in  1  level; high = run repeated measurements
ECHO  in  1  raw sensor echo, asynchronous to clk
TRIGGER  out  1  sensor trigger pulse, registered
distance  out  8  last result in cm, saturating at 255
valid  out  1  one-cycle strobe when distance/error/overrange update
error  out  1  last measurement saw no echo
overrange  out  1  last measurement saturated at 255 cm
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, async): state IDLE; TRIGGER=0, distance=0, valid=0, error=0, overrange=0, busy=0; all counters cleared; synchroniser flops cleared to 0.
- ECHO passes through a 2-FF synchroniser, then a registered edge detector. Only the synchronised signal (echo_s) is used internally.
- States: IDLE, TRIG, WAIT_ECHO, MEASURE, DONE, HOLDOFF.
- IDLE: ENABLE=1 moves to TRIG on the next edge. ENABLE=0 stays in IDLE.
- TRIG: TRIGGER=1 for exactly TRIG_CYCLES cycles, then TRIGGER=0 and move to WAIT_ECHO.
- WAIT_ECHO: waits for a rising edge of echo_s.
  - An echo_s already high on entry is not a rising edge; a stale echo is ignored.
  - Rising edge -> MEASURE, with the cm counter and prescaler cleared.
  - WAIT_CYCLES elapsed with no rise -> DONE with no_echo set.
- MEASURE:
  - Prescaler counts 0..CYCLES_PER_CM-1 while echo_s=1; each wrap increments cm.
  - The partial final centimetre is truncated.
  - Falling edge of echo_s -> DONE.
  - cm reaching 255 while echo_s is still 1 -> DONE with sat set. No waiting for the fall.
- DONE (1 cycle): valid=1.
  - distance = 255 if no_echo, else cm.
  - error = no_echo; overrange = sat.
  - Then move to HOLDOFF.
- HOLDOFF: HOLDOFF_CYCLES cycles, then IDLE.
- Latency: valid rises exactly 4 clk cycles after the first clk edge that samples ECHO low (2 sync + 1 edge register + DONE).
- distance, error and overrange hold their values between valid strobes.
- ENABLE dropping mid-cycle does not abort; the sequence completes through HOLDOFF and then parks in IDLE. ENABLE held high gives back-to-back measurements.
- ECHO glitching high during TRIG or HOLDOFF has no effect.
- Reset asserted in any state returns immediately to reset values, including dropping TRIGGER mid-pulse.

Decomposition:
- Package ultrasonido_pkg: state enumeration, default timing constants (TRIG_CYCLES, CYCLES_PER_CM, WAIT_CYCLES, HOLDOFF_CYCLES), DIST_MAX=255.
- Sub-module echo_sync: 2-FF synchroniser plus rise/fall pulse outputs. Uses the same clk and reset ports.

Test Plan:
Bench parameters: TRIG_CYCLES=4, CYCLES_PER_CM=10, WAIT_CYCLES=100, HOLDOFF_CYCLES=20.
1. Reset low, then high with ENABLE=1 -> TRIGGER high for exactly 4 cycles one cycle after reset release; all outputs 0 during reset.
2. ECHO high 20 cycles after trigger, held 235 cycles -> valid pulse with distance=23, error=0, overrange=0; valid 4 cycles after ECHO falls.
3. ECHO never rises -> after 100 WAIT cycles, valid with distance=255, error=1, overrange=0; next TRIGGER 21 cycles later.
4. ECHO high for 3000 cycles -> valid when cm hits 255 (ECHO still high), distance=255, overrange=1, error=0; no second result at the ECHO fall.
5. ENABLE dropped during MEASURE (ECHO 57 cycles) -> result distance=5 still delivered, HOLDOFF completes, busy=0, no further TRIGGER.
6. ECHO held high from before the trigger through WAIT_ECHO, falls, then rises 30 cycles later for 100 cycles -> distance=10; reset pulsed mid-TRIG in a separate run -> TRIGGER drops immediately.
